// File: rtl/fpu_pkg.sv
// Shared types and helpers for the sequential floating-point add/sub unit.
// Latency: n/a (types, constants and a pure packing function only).
// Backpressure: n/a.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    PACK
  } state_t;

  // Bit positions inside the one-hot status word.
  localparam int STAT_EXACT   = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_UNF     = 2;
  localparam int STAT_INEXACT = 3;

  // Assembles {sign, exp, mant} for any field widths up to 64 bits total;
  // fields are masked to their widths so stray upper bits cannot leak in.
  function automatic logic [63:0] pack_word(input logic        sign,
                                            input logic [63:0] exp,
                                            input logic [63:0] mant,
                                            input int          exp_w,
                                            input int          mant_w);
    logic [63:0] emask;
    logic [63:0] mmask;
    emask = (64'd1 << exp_w) - 64'd1;
    mmask = (64'd1 << mant_w) - 64'd1;
    return ({63'd0, sign} << (exp_w + mant_w)) | ((exp & emask) << mant_w) | (mant & mmask);
  endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Splits a packed float into sign, exponent and extended significand.
// Latency: combinational.
// Backpressure: none; pure function of the input word.
module fpu_unpack
  import fpu_pkg::*;
#(
  parameter  int EXP_W  = 6,
  parameter  int MANT_W = 25,
  localparam int W      = 1 + EXP_W + MANT_W,
  localparam int SIG_W  = MANT_W + 5
) (
  input  logic [W-1:0]      word,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [SIG_W-1:0]  sig
);

  logic is_zero;

  // Significand layout: {carry, hidden, mant, guard, round, sticky}.
  // A zero exponent encodes zero, so the mantissa is discarded there.
  always_comb begin
    sign    = word[W-1];
    exp     = word[W-2:MANT_W];
    is_zero = (exp == '0);
    sig     = is_zero ? '0 : {2'b01, word[MANT_W-1:0], 3'b000};
  end

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle float add/sub with bit-serial alignment and normalisation.
// Latency: d'+n+4 cycles from the start-sampling edge (d' = clamped exp diff, n = left shifts).
// Backpressure: start is only sampled in IDLE; busy high while in flight, done pulses one cycle.
module fpu_addsub_seq
  import fpu_pkg::*;
#(
  parameter  int EXP_W  = 6,
  parameter  int MANT_W = 25,
  parameter  int BIAS   = 2**(EXP_W-1) - 1,
  localparam int W      = 1 + EXP_W + MANT_W
) (
  input  logic         clock100KHz,
  input  logic         reset,
  input  logic         start,
  input  logic         op_sel,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);

  localparam int SIG_W  = MANT_W + 5;
  localparam int MAX_SH = MANT_W + 3;
  localparam int CNT_W  = $clog2(MAX_SH + 1);
  localparam int EMAX   = 2**EXP_W - 1;

  // The datapath never needs the bias (only exponent differences matter),
  // but a bias outside the exponent range is a configuration error.
  if (BIAS <= 0 || BIAS >= EMAX) begin : g_bias_check
    $error("fpu_addsub_seq: BIAS out of range");
  end

  state_t state, state_d;

  logic             a_sign, b_sign_raw, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [SIG_W-1:0] a_sig, b_sig;

  logic             big_sign, small_sign, res_sign, unf;
  logic [EXP_W:0]   exp_r;
  logic [SIG_W-1:0] big_sig, small_sig;
  logic [CNT_W-1:0] cnt;

  logic             a_big;
  logic [EXP_W-1:0] exp_diff;
  logic [CNT_W-1:0] sh_c;
  logic [SIG_W-1:0] mag_sum, mag_diff;
  logic             norm_done;

  fpu_unpack #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_unpack_a (
    .word (op_A_in),
    .sign (a_sign),
    .exp  (a_exp),
    .sig  (a_sig)
  );

  fpu_unpack #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_unpack_b (
    .word (op_B_in),
    .sign (b_sign_raw),
    .exp  (b_exp),
    .sig  (b_sig)
  );

  // Capture-time operand ordering, clamped shift distance and add/sub magnitudes.
  always_comb begin
    b_sign    = b_sign_raw ^ op_sel;
    a_big     = (a_exp >= b_exp);
    exp_diff  = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
    sh_c      = (32'(exp_diff) > MAX_SH) ? CNT_W'(MAX_SH) : CNT_W'(exp_diff);
    mag_sum   = big_sig + small_sig;
    mag_diff  = big_sig - small_sig;
    norm_done = big_sig[SIG_W-1] || (big_sig == '0) || big_sig[SIG_W-2]
                || (exp_r <= (EXP_W+1)'(1));
  end

  // FSM state register.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state sequencing through align, add, normalise and pack.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = ALIGN;
      ALIGN:   if (cnt == '0) state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    if (norm_done) state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers and result/status outputs.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      res_sign   <= 1'b0;
      unf        <= 1'b0;
      exp_r      <= '0;
      big_sig    <= '0;
      small_sig  <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            big_sign   <= a_big ? a_sign : b_sign;
            small_sign <= a_big ? b_sign : a_sign;
            exp_r      <= {1'b0, (a_big ? a_exp : b_exp)};
            big_sig    <= a_big ? a_sig : b_sig;
            small_sig  <= a_big ? b_sig : a_sig;
            cnt        <= sh_c;
            unf        <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ALIGN: begin
          // Bits falling off the bottom are folded into sticky.
          if (cnt != '0) begin
            small_sig <= {1'b0, small_sig[SIG_W-1:2], small_sig[1] | small_sig[0]};
            cnt       <= cnt - 1'b1;
          end
        end
        ADD: begin
          // Both significands have a clear carry bit, so a set top bit of
          // the difference means small > big.
          if (big_sign == small_sign) begin
            big_sig  <= mag_sum;
            res_sign <= big_sign;
          end else if (mag_diff[SIG_W-1]) begin
            big_sig  <= small_sig - big_sig;
            res_sign <= small_sign;
          end else begin
            big_sig  <= mag_diff;
            res_sign <= big_sign;
          end
        end
        NORM: begin
          if (big_sig[SIG_W-1]) begin
            big_sig <= {1'b0, big_sig[SIG_W-1:2], big_sig[1] | big_sig[0]};
            exp_r   <= exp_r + 1'b1;
          end else if ((big_sig == '0) || big_sig[SIG_W-2]) begin
            // already normalised (or zero)
          end else if (exp_r <= (EXP_W+1)'(1)) begin
            unf <= 1'b1;
          end else begin
            big_sig <= big_sig << 1;
            exp_r   <= exp_r - 1'b1;
          end
        end
        PACK: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (exp_r > (EXP_W+1)'(EMAX)) begin
            data_out   <= {res_sign, {(W-1){1'b1}}};
            status_out <= 4'b0001 << STAT_OVF;
          end else if (unf) begin
            data_out   <= '0;
            status_out <= 4'b0001 << STAT_UNF;
          end else if (big_sig == '0) begin
            data_out   <= '0;
            status_out <= 4'b0001 << STAT_EXACT;
          end else begin
            data_out   <= W'(pack_word(res_sign, 64'(exp_r[EXP_W-1:0]),
                                       64'(big_sig[MANT_W+2:3]), EXP_W, MANT_W));
            status_out <= (|big_sig[2:0]) ? (4'b0001 << STAT_INEXACT)
                                          : (4'b0001 << STAT_EXACT);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed vector bench for fpu_addsub_seq with hand-computed results.
// Latency: checks done timing in cycles from the start-sampling edge.
// Backpressure: exercises start-while-busy, back-to-back start and mid-op reset.
module tb_fpu_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_sel;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int passed = 0;
  int total  = 0;

  fpu_addsub_seq dut (
    .clock100KHz (clk),
    .reset       (rst_n),
    .start       (start),
    .op_sel      (op_sel),
    .op_A_in     (op_a),
    .op_B_in     (op_b),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp_v);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic op);
    @(negedge clk);
    op_a   = a;
    op_b   = b;
    op_sel = op;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns cycles after the sampling edge at which done is seen, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;

    vec[0]  = '{32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0001, 4};   // 1+1
    vec[1]  = '{32'h3E000000, 32'hBE000000, 1'b0, 32'h00000000, 4'b0001, 4};   // 1+(-1)
    vec[2]  = '{32'h42000000, 32'h40000000, 1'b1, 32'h40000000, 4'b0001, 6};   // 4-2
    vec[3]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 4'b0010, 4};   // overflow
    vec[4]  = '{32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b1000, 30};  // guard bit
    vec[5]  = '{32'h02000001, 32'h82000000, 1'b0, 32'h00000000, 4'b0100, 4};   // underflow
    vec[6]  = '{32'h3E000000, 32'h40000000, 1'b1, 32'hBE000000, 4'b0001, 6};   // 1-2 = -1
    vec[7]  = '{32'h3E000000, 32'hBF000000, 1'b0, 32'hBC000000, 4'b0001, 5};   // 1-1.5 = -0.5
    vec[8]  = '{32'h00000000, 32'h3E000000, 1'b0, 32'h3E000000, 4'b0001, 32};  // 0+1, clamp
    vec[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0001, 4};   // -0+-0 = +0
    vec[10] = '{32'h3E000000, 32'h02000000, 1'b0, 32'h3E000000, 4'b1000, 32};  // sticky, clamp
    vec[11] = '{32'h3FFFFFFF, 32'h0C000000, 1'b0, 32'h40000000, 4'b0001, 29};  // carry, exact

    rst_n  = 1'b0;
    start  = 1'b0;
    op_sel = 1'b0;
    op_a   = '0;
    op_b   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset busy",   {31'd0, busy}, 32'd0);
    chk("reset done",   {31'd0, done}, 32'd0);
    chk("reset data",   data_out, 32'd0);
    chk("reset status", {28'd0, status_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      launch(vec[i].a, vec[i].b, vec[i].op);
      wait_done(lat);
      chk($sformatf("v%0d data", i),    data_out, vec[i].d);
      chk($sformatf("v%0d status", i),  {28'd0, status_out}, {28'd0, vec[i].s});
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vec[i].lat));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done pulse", i), {31'd0, done}, 32'd0);
    end

    // start re-pulsed while busy must be ignored
    launch(32'h3E000000, 32'h0A000000, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("busy in flight", {31'd0, busy}, 32'd1);
    op_a  = 32'h7FFFFFFF;
    op_b  = 32'h7FFFFFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("ignore data",    data_out, 32'h3E000000);
    chk("ignore status",  {28'd0, status_out}, 32'b1000);
    chk("ignore latency", 32'(lat + 4), 32'd30);

    // start during the done cycle is accepted
    op_a   = 32'h3E000000;
    op_b   = 32'h3E000000;
    op_sel = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("b2b data",    data_out, 32'h40000000);
    chk("b2b status",  {28'd0, status_out}, 32'b0001);
    chk("b2b latency", 32'(lat), 32'd4);

    // reset in the middle of ALIGN aborts silently
    launch(32'h3E000000, 32'h0A000000, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort busy",   {31'd0, busy}, 32'd0);
    chk("abort done",   {31'd0, done}, 32'd0);
    chk("abort data",   data_out, 32'd0);
    chk("abort status", {28'd0, status_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort no done", 32'(ndone), 32'd0);
    chk("abort idle",    {31'd0, busy}, 32'd0);

    launch(32'h42000000, 32'h40000000, 1'b1);
    wait_done(lat);
    chk("post reset data",    data_out, 32'h40000000);
    chk("post reset status",  {28'd0, status_out}, 32'b0001);
    chk("post reset latency", 32'(lat), 32'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
